// File: rtl/step_drv.sv
// step_drv: per-axis STEP/DIR regenerator with a pending-direction FIFO and position counters.
// Define STEP_DRV_INVERT_EN to add step_inv/dir_inv polarity inputs on the driver outputs.
module step_drv #(
  parameter int unsigned N_AXES     = 8,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TW         = 8,
  parameter int unsigned POS_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          aclr_n,
  input  logic [N_AXES-1:0]             pls,
  input  logic [N_AXES-1:0]             dir,
  input  logic                          abort,
  input  logic                          enable,
  input  logic [TW-1:0]                 pw_high,
  input  logic [TW-1:0]                 pw_low,
  input  logic [TW-1:0]                 dir_setup,
  input  logic                          clr_err,
  input  logic                          pos_we,
  input  logic [2:0]                    pos_sel,
  input  logic [POS_WIDTH-1:0]          pos_value,
`ifdef STEP_DRV_INVERT_EN
  input  logic [N_AXES-1:0]             step_inv,
  input  logic [N_AXES-1:0]             dir_inv,
`endif
  output logic [N_AXES-1:0]             step_out,
  output logic [N_AXES-1:0]             dir_out,
  output logic [N_AXES-1:0]             busy,
  output logic [N_AXES-1:0]             ovf,
  output logic [N_AXES*POS_WIDTH-1:0]   pos
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  state_t                r_state   [N_AXES];
  state_t                w_state_nx[N_AXES];
  logic [TW-1:0]         r_tcnt    [N_AXES];
  logic [TW-1:0]         w_tcnt_nx [N_AXES];
  logic [N_AXES-1:0]     r_step, w_step_nx, r_dir, w_dir_nx;
  logic [N_AXES-1:0]     r_pls, r_pdir, r_ovf;
  logic [N_AXES-1:0]     w_pop, w_rise, w_push, w_push_ok, w_ovf_set, w_head;
  logic [DEPTH-1:0]      r_fifo    [N_AXES];
  logic [DEPTH_LOG2-1:0] r_wptr    [N_AXES];
  logic [DEPTH_LOG2-1:0] r_rptr    [N_AXES];
  logic [CW-1:0]         r_cnt     [N_AXES];
  logic [POS_WIDTH-1:0]  r_pos     [N_AXES];
  logic [TW-1:0]         w_ph, w_pl, w_ds;

  // Reload values are max(x,1)-1 so a programmed 0 behaves as 1.
  assign w_ph = (pw_high   == '0) ? '0 : pw_high   - TW'(1);
  assign w_pl = (pw_low    == '0) ? '0 : pw_low    - TW'(1);
  assign w_ds = (dir_setup == '0) ? '0 : dir_setup - TW'(1);

  always_comb begin
    w_step_nx = r_step;
    w_dir_nx  = r_dir;
    w_pop     = '0;
    w_rise    = '0;
    w_push    = '0;
    w_push_ok = '0;
    w_ovf_set = '0;
    w_head    = '0;
    for (int unsigned i = 0; i < N_AXES; i++) begin
      w_state_nx[i] = r_state[i];
      w_tcnt_nx[i]  = r_tcnt[i];
      w_head[i]     = r_fifo[i][r_rptr[i]];
      if (abort) begin
        w_state_nx[i] = S_IDLE;
        w_step_nx[i]  = 1'b0;
      end else begin
        unique case (r_state[i])
          S_IDLE: if (r_cnt[i] != '0 && enable) begin
            w_pop[i] = 1'b1;
            if (w_head[i] == r_dir[i]) begin
              w_step_nx[i]  = 1'b1;
              w_tcnt_nx[i]  = w_ph;
              w_state_nx[i] = S_HIGH;
              w_rise[i]     = 1'b1;
            end else begin
              w_dir_nx[i]   = w_head[i];
              w_tcnt_nx[i]  = w_ds;
              w_state_nx[i] = S_SETUP;
            end
          end
          S_SETUP: if (r_tcnt[i] == '0) begin
            w_step_nx[i]  = 1'b1;
            w_tcnt_nx[i]  = w_ph;
            w_state_nx[i] = S_HIGH;
            w_rise[i]     = 1'b1;
          end else w_tcnt_nx[i] = r_tcnt[i] - TW'(1);
          S_HIGH: if (r_tcnt[i] == '0) begin
            w_step_nx[i]  = 1'b0;
            w_tcnt_nx[i]  = w_pl;
            w_state_nx[i] = S_LOW;
          end else w_tcnt_nx[i] = r_tcnt[i] - TW'(1);
          S_LOW: if (r_tcnt[i] == '0) w_state_nx[i] = S_IDLE;
                 else w_tcnt_nx[i] = r_tcnt[i] - TW'(1);
          default: w_state_nx[i] = S_IDLE;
        endcase
        w_push[i] = r_pls[i];
      end
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      w_push_ok[i] = w_push[i] && (r_cnt[i] != CW'(DEPTH) || w_pop[i]);
      w_ovf_set[i] = w_push[i] && r_cnt[i] == CW'(DEPTH) && !w_pop[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      for (int unsigned i = 0; i < N_AXES; i++) begin
        r_state[i] <= S_IDLE;
        r_tcnt[i]  <= '0;
      end
      r_step <= '0;
      r_dir  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_AXES; i++) begin
        r_state[i] <= w_state_nx[i];
        r_tcnt[i]  <= w_tcnt_nx[i];
      end
      r_step <= w_step_nx;
      r_dir  <= w_dir_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      r_pls  <= '0;
      r_pdir <= '0;
      r_ovf  <= '0;
      for (int unsigned i = 0; i < N_AXES; i++) begin
        r_fifo[i] <= '0;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
        r_pos[i]  <= '0;
      end
    end else begin
      r_pls  <= abort ? '0 : pls;
      r_pdir <= dir;
      r_ovf  <= (r_ovf & ~{N_AXES{clr_err}}) | w_ovf_set;
      for (int unsigned i = 0; i < N_AXES; i++) begin
        if (abort) begin
          r_wptr[i] <= '0;
          r_rptr[i] <= '0;
          r_cnt[i]  <= '0;
        end else begin
          if (w_pop[i]) r_rptr[i] <= r_rptr[i] + DEPTH_LOG2'(1);
          if (w_push_ok[i]) begin
            r_fifo[i][r_wptr[i]] <= r_pdir[i];
            r_wptr[i]            <= r_wptr[i] + DEPTH_LOG2'(1);
          end
          if (w_push_ok[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CW'(1);
          else if (!w_push_ok[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
        end
        if (pos_we && 32'(pos_sel) == i)
          r_pos[i] <= pos_value;
        else if (w_rise[i])
          r_pos[i] <= r_dir[i] ? r_pos[i] + POS_WIDTH'(1) : r_pos[i] - POS_WIDTH'(1);
      end
    end
  end

  always_comb begin
    busy = '0;
    pos  = '0;
    for (int unsigned i = 0; i < N_AXES; i++) begin
      busy[i] = (r_cnt[i] != '0) || (r_state[i] != S_IDLE);
      pos[i*POS_WIDTH +: POS_WIDTH] = r_pos[i];
    end
  end

  assign ovf = r_ovf;
`ifdef STEP_DRV_INVERT_EN
  assign step_out = r_step ^ step_inv;
  assign dir_out  = r_dir ^ dir_inv;
`else
  assign step_out = r_step;
  assign dir_out  = r_dir;
`endif

endmodule

// File: tb/tb_step_drv.sv
// tb_step_drv: directed and randomized checks of step_drv against a deadline/queue model.
module tb_step_drv;
  localparam int N     = 8;
  localparam int PW    = 32;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            aclr_n = 1'b0;
  logic [N-1:0]    pls = '0, dir = '0;
  logic            abort = 1'b0, enable = 1'b1;
  logic [7:0]      pw_high = 8'd3, pw_low = 8'd2, dir_setup = 8'd4;
  logic            clr_err = 1'b0, pos_we = 1'b0;
  logic [2:0]      pos_sel = '0;
  logic [PW-1:0]   pos_value = '0;
  logic [N-1:0]    step_out, dir_out, busy, ovf;
  logic [N*PW-1:0] pos;
`ifdef STEP_DRV_INVERT_EN
  logic [N-1:0]    step_inv = '0, dir_inv = '0;
`endif

  always #5 clk = ~clk;

  step_drv #(.N_AXES(N), .DEPTH_LOG2(3), .TW(8), .POS_WIDTH(PW)) dut (
    .clk(clk), .aclr_n(aclr_n), .pls(pls), .dir(dir), .abort(abort), .enable(enable),
    .pw_high(pw_high), .pw_low(pw_low), .dir_setup(dir_setup), .clr_err(clr_err),
    .pos_we(pos_we), .pos_sel(pos_sel), .pos_value(pos_value),
`ifdef STEP_DRV_INVERT_EN
    .step_inv(step_inv), .dir_inv(dir_inv),
`endif
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .ovf(ovf), .pos(pos));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pos_of(input int a);
    return pos[a*PW +: PW];
  endfunction

  // Model: pending directions as queues, pulse phases as absolute edge deadlines.
  longint       cyc = 0;
  int           m_mode [N];   // 0 idle, 1 waiting for dir setup, 2 high, 3 low
  longint       m_tend [N];
  bit           m_q    [N][$];
  logic [N-1:0] m_step, m_dir, m_ovf, m_ppls, m_pdir;
  logic [PW-1:0] m_pos [N];
  bit           mp, mr, mo, mh;

  function automatic longint atleast1(input logic [7:0] v);
    return (v == 0) ? 64'd1 : longint'(v);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!aclr_n) begin
      for (int i = 0; i < N; i++) begin
        m_q[i].delete();
        m_mode[i] = 0;
        m_tend[i] = 0;
        m_pos[i]  = '0;
      end
      m_step = '0; m_dir = '0; m_ovf = '0; m_ppls = '0; m_pdir = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        mp = 0; mr = 0; mo = 0;
        if (abort) begin
          m_q[i].delete();
          m_mode[i] = 0;
          m_step[i] = 1'b0;
        end else begin
          case (m_mode[i])
            0: if (m_q[i].size() > 0 && enable) begin
              mh = m_q[i].pop_front();
              mp = 1;
              if (mh == m_dir[i]) begin
                m_step[i] = 1'b1; m_mode[i] = 2; m_tend[i] = cyc + atleast1(pw_high); mr = 1;
              end else begin
                m_dir[i] = mh; m_mode[i] = 1; m_tend[i] = cyc + atleast1(dir_setup);
              end
            end
            1: if (cyc == m_tend[i]) begin
              m_step[i] = 1'b1; m_mode[i] = 2; m_tend[i] = cyc + atleast1(pw_high); mr = 1;
            end
            2: if (cyc == m_tend[i]) begin
              m_step[i] = 1'b0; m_mode[i] = 3; m_tend[i] = cyc + atleast1(pw_low);
            end
            default: if (cyc == m_tend[i]) m_mode[i] = 0;
          endcase
          if (m_ppls[i]) begin
            if (m_q[i].size() >= DEPTH) mo = 1;
            else m_q[i].push_back(m_pdir[i]);
          end
        end
        if (clr_err) m_ovf[i] = 1'b0;
        if (mo) m_ovf[i] = 1'b1;
        if (pos_we && int'(pos_sel) == i) m_pos[i] = pos_value;
        else if (mr) m_pos[i] = m_dir[i] ? m_pos[i] + 1 : m_pos[i] - 1;
      end
      m_ppls = abort ? '0 : pls;
      m_pdir = dir;
    end
  end

  int           rise_cnt [N];
  logic [N-1:0] prev_step = '0;
  logic [N-1:0] m_busy;
  logic [N*PW-1:0] m_pos_flat;

  initial for (int i = 0; i < N; i++) rise_cnt[i] = 0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      m_busy[i] = (m_q[i].size() > 0) || (m_mode[i] != 0);
      m_pos_flat[i*PW +: PW] = m_pos[i];
      if (step_out[i] === 1'b1 && prev_step[i] === 1'b0) rise_cnt[i]++;
    end
    prev_step = step_out;
`ifdef STEP_DRV_INVERT_EN
    chk("step_out", step_out, m_step ^ step_inv);
    chk("dir_out", dir_out, m_dir ^ dir_inv);
`else
    chk("step_out", step_out, m_step);
    chk("dir_out", dir_out, m_dir);
`endif
    chk("busy", busy, m_busy);
    chk("ovf", ovf, m_ovf);
    chk("pos", pos, m_pos_flat);
  end

  task automatic drive_one(input int ax, input bit d);
    @(negedge clk); pls[ax] = 1'b1; dir[ax] = d;
    @(posedge clk);
    @(negedge clk); pls[ax] = 1'b0;
  endtask

  task automatic wait_idle(input int ax, input int budget);
    int k = 0;
    repeat (2) @(posedge clk);
    #1;
    while (busy[ax] !== 1'b0 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk("idle_in_budget", busy[ax], 1'b0);
  endtask

  task automatic load_pos(input int ax, input logic [PW-1:0] v);
    @(negedge clk); pos_we = 1'b1; pos_sel = 3'(ax); pos_value = v;
    @(negedge clk); pos_we = 1'b0;
  endtask

  int r0, k2, dens;
  logic [PW-1:0] psave;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pos", pos, '0);
    chk("rst_step", step_out, '0);
    chk("rst_busy", busy, '0);
    aclr_n = 1'b1;

    // first step in positive direction needs a dir change from reset level 0
    drive_one(0, 1'b1);
    wait_idle(0, 50);
    chk("t1_dir", dir_out[0], 1'b1);
    chk("t1_pos", pos_of(0), 32'd1);

    // same direction: high during E+2..E+4
    drive_one(0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("t2_step", step_out[0], (k >= 2 && k <= 4));
    end
    wait_idle(0, 50);
    chk("t2_pos", pos_of(0), 32'd2);

    // direction reversal with setup of 4
    load_pos(0, 32'd0);
    drive_one(0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("t3_dir_before", dir_out[0], 1'b1);
      if (k == 2) chk("t3_dir_after", dir_out[0], 1'b0);
      if (k == 5) chk("t3_step_setup", step_out[0], 1'b0);
      if (k == 6) chk("t3_step_rise", step_out[0], 1'b1);
    end
    wait_idle(0, 50);
    chk("t3_pos", pos_of(0), 32'hFFFF_FFFF);

    // overflow: 1 popped, 8 buffered, 1 dropped
    @(negedge clk); pw_high = 8'd10; pw_low = 8'd10;
    r0 = rise_cnt[2];
    pls[2] = 1'b1; dir[2] = 1'b1;
    repeat (10) @(negedge clk);
    pls[2] = 1'b0;
    wait_idle(2, 400);
    chk("t4_ovf", ovf[2], 1'b1);
    chk("t4_pulses", 32'(rise_cnt[2] - r0), 32'd9);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("t4_ovf_clr", ovf[2], 1'b0);

    // abort during HIGH with 5 pending
    @(negedge clk); pls[3] = 1'b1; dir[3] = 1'b0;
    repeat (6) @(negedge clk);
    pls[3] = 1'b0;
    k2 = 0;
    while (step_out[3] !== 1'b1 && k2 < 20) begin @(posedge clk); #1; k2++; end
    chk("t5_in_high", step_out[3], 1'b1);
    psave = pos_of(3);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    chk("t5_step_low", step_out[3], 1'b0);
    chk("t5_not_busy", busy[3], 1'b0);
    @(negedge clk); abort = 1'b0;
    r0 = rise_cnt[3];
    repeat (40) @(posedge clk);
    #1;
    chk("t5_no_pulses", 32'(rise_cnt[3] - r0), 32'd0);
    chk("t5_pos_held", pos_of(3), psave);
    @(negedge clk); pw_high = 8'd3; pw_low = 8'd2;

    // wrap and load-vs-step
    load_pos(1, 32'h7FFF_FFFF);
    drive_one(1, 1'b1);
    wait_idle(1, 50);
    chk("t6_wrap", pos_of(1), 32'h8000_0000);
    drive_one(1, 1'b1);
    @(posedge clk);
    @(negedge clk); pos_we = 1'b1; pos_sel = 3'd1; pos_value = 32'h1234_5678;
    @(posedge clk); #1;
    chk("t6_rise", step_out[1], 1'b1);
    chk("t6_load_wins", pos_of(1), 32'h1234_5678);
    @(negedge clk); pos_we = 1'b0;
    wait_idle(1, 50);
    chk("t6_load_kept", pos_of(1), 32'h1234_5678);

    // enable stall
    @(negedge clk); enable = 1'b0;
    r0 = rise_cnt[4];
    repeat (3) drive_one(4, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("t7_stalled", 32'(rise_cnt[4] - r0), 32'd0);
    chk("t7_busy", busy[4], 1'b1);
    @(negedge clk); enable = 1'b1;
    wait_idle(4, 200);
    chk("t7_pulses", 32'(rise_cnt[4] - r0), 32'd3);

    // randomized traffic
    dens = 4;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 500 == 0) dens = $urandom_range(1, 12);
      for (int a = 0; a < N; a++) begin
        pls[a] = ($urandom_range(dens) == 0);
        dir[a] = $urandom_range(1);
      end
      abort   = ($urandom_range(299) == 0);
      aclr_n  = ($urandom_range(1499) != 0);
      clr_err = ($urandom_range(59) == 0);
      if ($urandom_range(49) == 0) enable = ~enable;
      if ($urandom_range(39) == 0) pw_high   = 8'($urandom_range(0, 4));
      if ($urandom_range(39) == 0) pw_low    = 8'($urandom_range(0, 4));
      if ($urandom_range(39) == 0) dir_setup = 8'($urandom_range(0, 4));
      pos_we    = !abort && ($urandom_range(49) == 0);
      pos_sel   = 3'($urandom_range(7));
      pos_value = $urandom;
    end
    @(negedge clk);
    pls = '0; abort = 1'b0; aclr_n = 1'b1; clr_err = 1'b0; pos_we = 1'b0; enable = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
